// File: rtl/exe_muldiv_unit.sv
// exe_muldiv_unit: iterative RV32M multiply/divide unit in the EXE stage.
// One shift-add (multiply) or restoring (divide) step per cycle on operand
// magnitudes, followed by a two's-complement sign fix on the last step.
// Divide-by-zero and signed-overflow cases finish in one cycle.
// Optional build macro MULDIV_EARLY_OUT_EN adds one-cycle completion for
// zero multiply operands and divides where |rs1| < |rs2|.
//
// Handshake: start is a level qualifier from ID/EXE and must stay stable
// while stall is high. The pipeline advances on every edge where stall is
// low, and result_valid marks the single edge on which result and rd_out
// are to be captured by EXE/MEM.
module exe_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6      // 2**CNT_W must exceed XLEN
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            stall,
    output logic            result_valid,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [2:0]          op_q;
    logic [4:0]          rd_q;
    logic                neg_q;
    logic [XLEN-1:0]     opb;        // multiplicand / divisor magnitude
    logic [2*XLEN-1:0]   acc;        // product, or {remainder, quotient}

    // ------------------------------------------------------------------
    // Operand decode for the IDLE cycle
    // ------------------------------------------------------------------
    logic            signed_a, signed_b, a_neg, b_neg, neg_in;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_by_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;

    // Magnitudes, result sign and the one-cycle special cases
    always_comb begin
        signed_a    = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        signed_b    = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg       = signed_a && rs1_val[XLEN-1];
        b_neg       = signed_b && rs2_val[XLEN-1];
        a_mag       = a_neg ? (~rs1_val + 1'b1) : rs1_val;
        b_mag       = b_neg ? (~rs2_val + 1'b1) : rs2_val;
        // remainder takes the dividend sign, everything else the product sign
        neg_in      = (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);

        div_by_zero = op[2] && (rs2_val == '0);
        div_ovf     = ((op == OP_DIV) || (op == OP_REM)) &&
                      (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);
        special     = div_by_zero || div_ovf;
        special_res = '0;
        if (div_by_zero)
            special_res = op[1] ? rs1_val : '1;
        else if (div_ovf)
            special_res = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
`ifdef MULDIV_EARLY_OUT_EN
        if (!special) begin
            if (!op[2] && ((rs1_val == '0) || (rs2_val == '0))) begin
                special     = 1'b1;
                special_res = '0;
            end else if (op[2] && (a_mag < b_mag)) begin
                special     = 1'b1;
                special_res = op[1] ? rs1_val : '0;
            end
        end
`endif
    end

    // ------------------------------------------------------------------
    // One iteration step and the final sign fix
    // ------------------------------------------------------------------
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     trial;
    logic              qbit;
    logic [XLEN-1:0]   rem_new;
    logic [2*XLEN-1:0] acc_next;
    logic [2*XLEN-1:0] mul_fix;
    logic [XLEN-1:0]   div_raw;
    logic [XLEN-1:0]   final_res;

    // Shift-add multiply step, restoring divide step, signed result
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
        trial     = acc[2*XLEN-1:XLEN-1] - {1'b0, opb};
        qbit      = !trial[XLEN];
        rem_new   = qbit ? trial[XLEN-1:0] : acc[2*XLEN-2:XLEN-1];
        acc_next  = op_q[2] ? {rem_new, acc[XLEN-2:0], qbit}
                            : {mul_sum, acc[XLEN-1:1]};

        // high product words need the sign fix applied to all 2*XLEN bits
        mul_fix   = neg_q ? (~acc_next + 1'b1) : acc_next;
        div_raw   = op_q[1] ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
        final_res = '0;
        if (op_q[2])
            final_res = neg_q ? (~div_raw + 1'b1) : div_raw;
        else if (op_q[1:0] == 2'd0)
            final_res = mul_fix[XLEN-1:0];
        else
            final_res = mul_fix[2*XLEN-1:XLEN];
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state, stall and result strobe
    always_comb begin
        state_nxt    = state;
        stall        = 1'b0;
        result_valid = 1'b0;
        busy         = (state != IDLE);
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    stall     = 1'b1;
                    state_nxt = special ? DONE : CALC;
                end
            end
            CALC: begin
                stall = 1'b1;
                if (flush)
                    state_nxt = IDLE;
                else if (cnt == '0)
                    state_nxt = DONE;
            end
            DONE: begin
                // start is ignored here so the retiring instruction never restarts
                result_valid = !flush;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, result/rd registration
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            op_q   <= '0;
            rd_q   <= '0;
            neg_q  <= 1'b0;
            opb    <= '0;
            acc    <= '0;
            result <= '0;
            rd_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        op_q  <= op;
                        rd_q  <= rd_in;
                        neg_q <= neg_in;
                        opb   <= b_mag;
                        acc   <= {{XLEN{1'b0}}, a_mag};
                        cnt   <= CNT_W'(XLEN-1);
                        if (special) begin
                            result <= special_res;
                            rd_out <= rd_in;
                        end
                    end
                end
                CALC: begin
                    if (!flush) begin
                        acc <= acc_next;
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == '0) begin
                            result <= final_res;
                            rd_out <= rd_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// tb_exe_muldiv_unit: directed bench for exe_muldiv_unit with hand-computed
// expected results, latencies and result_valid pulse counts.
module tb_exe_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs1_val = '0;
    logic [31:0] rs2_val = '0;
    logic [4:0]  rd_in = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic        result_valid;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        busy;

    int n_vec  = 0;
    int n_miss = 0;
    int pulses = 0;
    int p0;
    logic [31:0] last_result;
    logic [4:0]  last_rd;

    exe_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .op           (op),
        .rs1_val      (rs1_val),
        .rs2_val      (rs2_val),
        .rd_in        (rd_in),
        .flush        (flush),
        .stall        (stall),
        .result_valid (result_valid),
        .result       (result),
        .rd_out       (rd_out),
        .busy         (busy)
    );

    // clock and result pulse monitor
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (result_valid === 1'b1)
            pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction, count stalled cycles, check the DONE cycle,
    // then step past DONE and confirm the unit is idle with one pulse seen.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_stall);
        int cycles;
        int pstart;
        op      = o;
        rs1_val = a;
        rs2_val = b;
        rd_in   = rd;
        start   = 1'b1;
        flush   = 1'b0;
        #1;
        pstart = pulses;
        cycles = 0;
        while (stall && cycles < 100) begin
            tick();
            cycles++;
        end
        check({tag, " stall_cycles"}, 32'(cycles), 32'(exp_stall));
        check({tag, " result_valid"}, 32'(result_valid), 32'd1);
        check({tag, " result"}, result, exp);
        check({tag, " rd_out"}, 32'(rd_out), 32'(rd));
        tick();
        check({tag, " busy_after_done"}, 32'(busy), 32'd0);
        check({tag, " pulse_count"}, 32'(pulses - pstart), 32'd1);
        last_result = exp;
        last_rd     = rd;
    endtask

    initial begin
        // reset state, checked before any clock edge
        #2;
        check("reset stall", 32'(stall), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset result_valid", 32'(result_valid), 32'd0);
        check("reset result", result, 32'd0);
        check("reset rd_out", 32'(rd_out), 32'd0);
        #20 reset_n = 1'b1;
        tick();

        // multiply
        run_op("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 33);
        run_op("MULH -1*-1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'h0000_0000, 33);
        run_op("MULHU ff*ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 33);
        run_op("MULHSU -1*2", 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd8, 32'hFFFF_FFFF, 33);
        run_op("MULHU 2^16*2^16", 3'd3, 32'h0001_0000, 32'h0001_0000, 5'd10, 32'd1, 33);
        run_op("MUL 2^16*2^16", 3'd0, 32'h0001_0000, 32'h0001_0000, 5'd11, 32'd0, 33);
`ifdef MULDIV_EARLY_OUT_EN
        run_op("MUL 0*5", 3'd0, 32'd0, 32'd5, 5'd12, 32'd0, 1);
`else
        run_op("MUL 0*5", 3'd0, 32'd0, 32'd5, 5'd12, 32'd0, 33);
`endif

        // divide
        run_op("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd13, 32'hFFFF_FFFD, 33);
        run_op("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd14, 32'hFFFF_FFFF, 33);
        run_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 5'd15, 32'd14, 33);
        run_op("REMU 100/7", 3'd7, 32'd100, 32'd7, 5'd16, 32'd2, 33);
        run_op("DIV 20/-3", 3'd4, 32'd20, 32'hFFFF_FFFD, 5'd17, 32'hFFFF_FFFA, 33);
        run_op("REM 20/-3", 3'd6, 32'd20, 32'hFFFF_FFFD, 5'd18, 32'd2, 33);

        // divide by zero and signed overflow: one-cycle path
        run_op("DIVU 5/0", 3'd5, 32'd5, 32'd0, 5'd19, 32'hFFFF_FFFF, 1);
        run_op("REM 5/0", 3'd6, 32'd5, 32'd0, 5'd20, 32'd5, 1);
        run_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 32'h8000_0000, 1);
        run_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 32'd0, 1);

        // flush on CALC cycle 10
        op = 3'd0; rs1_val = 32'd11; rs2_val = 32'd13; rd_in = 5'd3; start = 1'b1;
        #1;
        p0 = pulses;
        repeat (10) tick();
        check("flush calc busy", 32'(busy), 32'd1);
        check("flush calc stall", 32'(stall), 32'd1);
        flush = 1'b1;
        #1;
        check("flush cycle result_valid", 32'(result_valid), 32'd0);
        tick();
        check("flush idle busy", 32'(busy), 32'd0);
        check("flush overrides start stall", 32'(stall), 32'd0);
        flush = 1'b0;
        start = 1'b0;
        #1;
        check("flush result_valid", 32'(result_valid), 32'd0);
        check("flush keeps result", result, last_result);
        check("flush keeps rd_out", 32'(rd_out), 32'(last_rd));
        check("flush no pulse", 32'(pulses - p0), 32'd0);
        run_op("MUL after flush", 3'd0, 32'd6, 32'd7, 5'd9, 32'd42, 33);

        // asynchronous reset in the middle of CALC
        op = 3'd0; rs1_val = 32'd9; rs2_val = 32'd9; rd_in = 5'd4; start = 1'b1;
        repeat (5) tick();
        check("pre-reset busy", 32'(busy), 32'd1);
        #3;
        reset_n = 1'b0;
        start   = 1'b0;
        #1;
        check("async reset stall", 32'(stall), 32'd0);
        check("async reset busy", 32'(busy), 32'd0);
        check("async reset result_valid", 32'(result_valid), 32'd0);
        check("async reset result", result, 32'd0);
        check("async reset rd_out", 32'(rd_out), 32'd0);
        #10 reset_n = 1'b1;
        tick();

        // back-to-back instructions, one idle cycle between them
        run_op("B2B MUL first", 3'd0, 32'd3, 32'd4, 5'd1, 32'd12, 33);
        run_op("B2B MUL second", 3'd0, 32'd5, 32'd5, 5'd2, 32'd25, 33);

        start = 1'b0;
        tick();
        check("final busy", 32'(busy), 32'd0);
        check("final result_valid", 32'(result_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
